// File: rtl/regfile.sv
// rtl/regfile.sv - NREGS x WIDTH register file, one write port, two bypassed read ports
//
// Ports:
//   clk              rising-edge clock for all storage updates
//   reset            asynchronous active-high clear of every word
//   wrEn             write enable
//   wrAddr, wrData   write address and data
//   rdAddr1, rdAddr2 read addresses (independent ports)
//   rdData1, rdData2 combinational read data
//
// Words are built one flop bank per register with a hold/load select.
// The ZERO_REG slot has no storage and reads as zero. Addresses outside
// 0..NREGS-1 are ignored for writes and read as zero. A write pending in
// the current cycle is forwarded to a matching read port, except while
// reset is asserted.

module regfile #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic [WIDTH-1:0]  rdData1,
    output logic [WIDTH-1:0]  rdData2
);

    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
    // One extra bit so NREGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W + 1)'(NREGS);

    logic [WIDTH-1:0] mem [NREGS];

    logic wr_ok;
    logic rd_ok1;
    logic rd_ok2;

    assign wr_ok  = wrEn && (wrAddr != ZERO_A) && ({1'b0, wrAddr} < NREGS_A);
    assign rd_ok1 = (rdAddr1 != ZERO_A) && ({1'b0, rdAddr1} < NREGS_A);
    assign rd_ok2 = (rdAddr2 != ZERO_A) && ({1'b0, rdAddr2} < NREGS_A);

    for (genvar i = 0; i < NREGS; i++) begin : g_word
        if (i == ZERO_REG) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_reg
            logic             load;
            logic [WIDTH-1:0] q;

            assign load = wr_ok && (wrAddr == ADDR_W'(i));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else if (load) begin
                    q <= wrData;
                end
            end

            assign mem[i] = q;
        end
    end

    // The pending write is only forwarded for valid, non-zero addresses;
    // the rd_ok guard already covers the ZERO_REG / out-of-range cases.
    always_comb begin
        rdData1 = '0;
        if (rd_ok1) begin
            if (wrEn && !reset && (rdAddr1 == wrAddr)) begin
                rdData1 = wrData;
            end else begin
                rdData1 = mem[rdAddr1];
            end
        end
    end

    always_comb begin
        rdData2 = '0;
        if (rd_ok2) begin
            if (wrEn && !reset && (rdAddr2 == wrAddr)) begin
                rdData2 = wrData;
            end else begin
                rdData2 = mem[rdAddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized self-checking bench for regfile with directed literal cases

module tb_regfile;

    logic        clk;
    logic        reset;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic [4:0]  rdAddr1;
    logic [4:0]  rdAddr2;
    logic [63:0] rdData1;
    logic [63:0] rdData2;

    int total;
    int bad;
    bit check_en;

    logic [63:0] model [32];

    regfile dut (
        .clk     (clk),
        .reset   (reset),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .rdAddr1 (rdAddr1),
        .rdAddr2 (rdAddr2),
        .rdData1 (rdData1),
        .rdData2 (rdData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state: register r holds the last value written to it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) model[r] = 64'h0;
        end else if (wrEn && wrAddr != 5'd31) begin
            model[wrAddr] = wrData;
        end
    end

    function automatic logic [63:0] expect_read(input logic [4:0] a);
        if (reset) return 64'h0;
        if (a == 5'd31) return 64'h0;
        if (wrEn && a == wrAddr) return wrData;
        return model[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("port1_model", rdData1, expect_read(rdAddr1));
            chk("port2_model", rdData2, expect_read(rdAddr2));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        reset    = 1'b1;
        wrEn     = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        rdAddr1  = '0;
        rdAddr2  = '0;

        step();
        step();
        reset    = 1'b0;
        check_en = 1'b1;

        // 1. every address reads zero after reset
        for (int i = 0; i < 32; i++) begin
            step();
            rdAddr1 = 5'(i);
            rdAddr2 = 5'(31 - i);
            #1;
            chk("reset_sweep1", rdData1, 64'h0);
            chk("reset_sweep2", rdData2, 64'h0);
        end

        // 2. simple write then read
        step();
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 64'hDEADBEEF_CAFEF00D;
        step();
        wrEn = 1'b0; rdAddr1 = 5'd5; rdAddr2 = 5'd4;
        #1;
        chk("write_x5", rdData1, 64'hDEADBEEF_CAFEF00D);
        chk("neighbor_x4", rdData2, 64'h0);

        // 3. same-cycle bypass on both ports, then from storage
        step();
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 64'h1234; rdAddr1 = 5'd7; rdAddr2 = 5'd7;
        #1;
        chk("bypass1", rdData1, 64'h1234);
        chk("bypass2", rdData2, 64'h1234);
        step();
        wrEn = 1'b0; wrData = 64'h0;
        #1;
        chk("stored1", rdData1, 64'h1234);
        chk("stored2", rdData2, 64'h1234);

        // 4. zero register ignores writes and never bypasses
        step();
        wrEn = 1'b1; wrAddr = 5'd31; wrData = 64'hFFFF_FFFF_FFFF_FFFF; rdAddr1 = 5'd31;
        #1;
        chk("xzr_same_cycle", rdData1, 64'h0);
        step();
        wrEn = 1'b0;
        #1;
        chk("xzr_after", rdData1, 64'h0);

        // 5. wrEn=0 holds the word
        step();
        wrEn = 1'b1; wrAddr = 5'd3; wrData = 64'hAA;
        step();
        wrEn = 1'b0; wrData = 64'hBB; rdAddr1 = 5'd3;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("hold_x3", rdData1, 64'hAA);

        // 6. mid-cycle reset clears storage and kills the pending write
        step();
        wrEn = 1'b1; wrAddr = 5'd10; wrData = 64'h55;
        step();
        wrData = 64'h66; rdAddr1 = 5'd10; rdAddr2 = 5'd3;
        #1;
        chk("pre_reset_bypass", rdData1, 64'h66);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_x10", rdData1, 64'h0);
        chk("async_reset_x3", rdData2, 64'h0);
        step();
        reset = 1'b0; wrEn = 1'b0;
        #1;
        chk("after_reset_x10", rdData1, 64'h0);

        // Randomized traffic checked by the negedge process
        for (int n = 0; n < 400; n++) begin
            step();
            reset  = ($urandom_range(0, 59) == 0);
            wrEn   = $urandom_range(0, 2) != 0;
            wrAddr = 5'($urandom_range(0, 31));
            wrData = {$urandom, $urandom};
            rdAddr1 = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            rdAddr2 = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) rdAddr2 = rdAddr1;
        end
        step();
        reset = 1'b0; wrEn = 1'b0;
        step();
        step();
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
